// File: rtl/grf_pkg.sv
// Shared types for the GRF write-port arbiter.
// MD result queue entry and register-file widths.
package grf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [DATA_W-1:0]     pc;
    } md_entry_t;

endpackage

// File: rtl/grf_write_arbiter_if.sv
// MD result handshake into the GRF write arbiter.
// Transfer happens when md_valid && md_ready.
interface grf_write_arbiter_if;
    import grf_pkg::*;

    logic                  md_valid;
    logic                  md_ready;
    logic [REG_ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0]     md_data;
    logic [DATA_W-1:0]     md_pc;

    modport master (
        output md_valid, md_addr, md_data, md_pc,
        input  md_ready
    );

    modport slave (
        input  md_valid, md_addr, md_data, md_pc,
        output md_ready
    );

endinterface

// File: rtl/grf_wq_fifo.sv
// Synchronous FIFO of MD results waiting for a free GRF write slot.
// DEPTH must be a power of two so the pointers wrap naturally.
module grf_wq_fifo
    import grf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  md_entry_t din,
    input  logic      pop,
    output md_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    md_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/grf_write_arbiter.sv
// Shares the GRF write port between WB (priority, same cycle) and queued
// MD results; starvation freeze request and pending-write scoreboard.
module grf_write_arbiter
    import grf_pkg::*;
#(
    parameter int MD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic [DATA_W-1:0]     wb_pc,
    output logic                  wb_stall,
    input  logic                  md_issue,
    input  logic [REG_ADDR_W-1:0] md_issue_addr,
    grf_write_arbiter_if.slave    md,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic                  rs_pending,
    output logic                  rt_pending,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] addr3,
    output logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     WPC
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    md_entry_t       push_entry;
    md_entry_t       head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [SW-1:0]   starve_q;
    logic [SW-1:0]   starve_d;
    logic [31:0]     sb_q;
    logic [31:0]     sb_d;

    assign md.md_ready = !full;
    assign push        = md.md_valid && !full;
    assign push_entry  = '{addr: md.md_addr, data: md.md_data, pc: md.md_pc};
    assign pop         = !reset && !wb_valid && !empty;

    grf_wq_fifo #(
        .DEPTH (MD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        RegWrite = 1'b0;
        addr3    = REG_ZERO;
        wd       = '0;
        WPC      = '0;
        priority case (1'b1)
            reset: ;
            wb_valid: begin
                if (wb_addr != REG_ZERO) begin
                    RegWrite = 1'b1;
                    addr3    = wb_addr;
                    wd       = wb_data;
                    WPC      = wb_pc;
                end
            end
            !empty: begin
                if (head.addr != REG_ZERO) begin
                    RegWrite = 1'b1;
                    addr3    = head.addr;
                    wd       = head.data;
                    WPC      = head.pc;
                end
            end
            default: ;
        endcase
    end

    // Retire clears first so a same-cycle reissue of that register wins.
    always_comb begin
        sb_d = sb_q;
        if (pop && head.addr != REG_ZERO) begin
            sb_d[head.addr] = 1'b0;
        end
        if (md_issue && md_issue_addr != REG_ZERO) begin
            sb_d[md_issue_addr] = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Stall is a single-cycle pulse; a saturated count re-arms it next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q     <= '0;
            starve_q <= '0;
            wb_stall <= 1'b0;
        end else begin
            sb_q     <= sb_d;
            starve_q <= starve_d;
            wb_stall <= (starve_d == STARVE_LIM) && !wb_stall;
        end
    end

    assign rs_pending = (rs_addr != REG_ZERO) && sb_q[rs_addr];
    assign rt_pending = (rt_addr != REG_ZERO) && sb_q[rt_addr];

endmodule
